phy_rx_link_ctrl: RTL and testbench

Link-training and lane-state controller for the two-lane PHY receive path. It sits after the per-lane serial-to-parallel converters and runs on the byte clock. It qualifies each lane's byte stream with a comma (BC) training sequence and monitors decode errors. It issues realign requests back to the converters, and passes qualified data and valid downstream together with a combined link_up indication.

---
 rtl/phy_rx_link_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_phy_rx_link_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_link_ctrl.sv
// Two-lane PHY receive link-training and lane-state controller.
// Optional saturating error counter enabled by PHY_RX_ERR_CNT_EN.
module phy_rx_lane #(
  parameter logic [7:0] BC_CODE        = 8'hBC,
  parameter int         BC_TO_ACTIVE   = 4,
  parameter int         ERR_TO_RETRAIN = 4,
  parameter int         TRAIN_TIMEOUT  = 64
) (
  input  logic       clk_f,
  input  logic       reset_L,
  input  logic       enable,
  input  logic       byte_vld,
  input  logic [7:0] byte_in,
  input  logic       code_err,
  output logic       realign,
  output logic       lane_active,
  output logic [7:0] data_out,
  output logic       valid_out
);
  localparam int BW = $clog2(BC_TO_ACTIVE) + 1;
  localparam int TW = $clog2(TRAIN_TIMEOUT) + 1;
  localparam int EW = $clog2(ERR_TO_RETRAIN) + 1;

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]    state, state_n;
  logic [BW-1:0] bc, bc_n, bc_inc;
  logic [TW-1:0] to, to_n, to_inc;
  logic [EW-1:0] run, run_n, run_inc;
  logic [7:0]    data_n;
  logic          valid_n, realign_n, clean_bc;

  assign clean_bc = (byte_in == BC_CODE) && !code_err;
  assign bc_inc   = bc + 1'b1;
  assign to_inc   = to + 1'b1;
  assign run_inc  = run + 1'b1;

  always_comb begin
    state_n   = state;
    bc_n      = bc;
    to_n      = to;
    run_n     = run;
    data_n    = data_out;
    valid_n   = 1'b0;
    realign_n = 1'b0;
    if (!enable) begin
      state_n = SEARCH;
      bc_n    = '0;
      to_n    = '0;
      run_n   = '0;
    end else if (byte_vld) begin
      unique case (state)
        SEARCH: begin
          bc_n = clean_bc ? bc_inc : '0;
          to_n = to_inc;
          // activation takes priority over a coincident timeout
          if (clean_bc && bc_inc == BW'(BC_TO_ACTIVE)) begin
            state_n = ACTIVE;
            bc_n    = '0;
            to_n    = '0;
          end else if (to_inc == TW'(TRAIN_TIMEOUT)) begin
            realign_n = 1'b1;
            bc_n      = '0;
            to_n      = '0;
          end
        end
        ACTIVE: begin
          if (code_err) begin
            run_n = run_inc;
            if (run_inc == EW'(ERR_TO_RETRAIN)) begin
              state_n   = SEARCH;
              realign_n = 1'b1;
              run_n     = '0;
              bc_n      = '0;
              to_n      = '0;
            end
          end else begin
            run_n = '0;
            if (byte_in != BC_CODE) begin
              data_n  = byte_in;
              valid_n = 1'b1;
            end
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= SEARCH;
      bc        <= '0;
      to        <= '0;
      run       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      realign   <= 1'b0;
    end else begin
      state     <= state_n;
      bc        <= bc_n;
      to        <= to_n;
      run       <= run_n;
      data_out  <= data_n;
      valid_out <= valid_n;
      realign   <= realign_n;
    end
  end

  assign lane_active = (state == ACTIVE);
endmodule

module phy_rx_link_ctrl #(
  parameter logic [7:0] BC_CODE        = 8'hBC,
  parameter int         BC_TO_ACTIVE   = 4,
  parameter int         ERR_TO_RETRAIN = 4,
  parameter int         TRAIN_TIMEOUT  = 64
) (
  input  logic       clk_f,
  input  logic       reset_L,
  input  logic       enable,
  input  logic       byte_vld_0,
  input  logic       byte_vld_1,
  input  logic [7:0] byte_0,
  input  logic [7:0] byte_1,
  input  logic       code_err_0,
  input  logic       code_err_1,
  output logic       realign_0,
  output logic       realign_1,
  output logic       lane_active_0,
  output logic       lane_active_1,
  output logic       link_up,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic [7:0] err_cnt
);
  phy_rx_lane #(
    .BC_CODE(BC_CODE), .BC_TO_ACTIVE(BC_TO_ACTIVE),
    .ERR_TO_RETRAIN(ERR_TO_RETRAIN), .TRAIN_TIMEOUT(TRAIN_TIMEOUT)
  ) u_lane0 (
    .clk_f(clk_f), .reset_L(reset_L), .enable(enable),
    .byte_vld(byte_vld_0), .byte_in(byte_0), .code_err(code_err_0),
    .realign(realign_0), .lane_active(lane_active_0),
    .data_out(data_out_0), .valid_out(valid_out_0)
  );

  phy_rx_lane #(
    .BC_CODE(BC_CODE), .BC_TO_ACTIVE(BC_TO_ACTIVE),
    .ERR_TO_RETRAIN(ERR_TO_RETRAIN), .TRAIN_TIMEOUT(TRAIN_TIMEOUT)
  ) u_lane1 (
    .clk_f(clk_f), .reset_L(reset_L), .enable(enable),
    .byte_vld(byte_vld_1), .byte_in(byte_1), .code_err(code_err_1),
    .realign(realign_1), .lane_active(lane_active_1),
    .data_out(data_out_1), .valid_out(valid_out_1)
  );

  // enable gates link_up so it drops with the lanes on disable
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) link_up <= 1'b0;
    else          link_up <= enable & lane_active_0 & lane_active_1;
  end

`ifdef PHY_RX_ERR_CNT_EN
  logic       e0, e1;
  logic [8:0] err_sum;
  assign e0      = enable & byte_vld_0 & code_err_0;
  assign e1      = enable & byte_vld_1 & code_err_1;
  assign err_sum = {1'b0, err_cnt} + 9'(e0) + 9'(e1);

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) err_cnt <= 8'h00;
    else          err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end
`else
  assign err_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// Self-checking bench for phy_rx_link_ctrl.
// Directed test-plan steps followed by randomized traffic.
module tb_phy_rx_link_ctrl;
  localparam int BC = 8'hBC;

  logic       clk_f = 1'b0;
  logic       reset_L = 1'b0;
  logic       enable = 1'b0;
  logic       byte_vld_0 = 1'b0, byte_vld_1 = 1'b0;
  logic [7:0] byte_0 = 8'h00, byte_1 = 8'h00;
  logic       code_err_0 = 1'b0, code_err_1 = 1'b0;
  logic       realign_0, realign_1;
  logic       lane_active_0, lane_active_1, link_up;
  logic [7:0] data_out_0, data_out_1;
  logic       valid_out_0, valid_out_1;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  int m_act[2], m_bc[2], m_to[2], m_run[2];
  int m_valid[2], m_realign[2], m_data[2];
  int m_link, m_err;

  phy_rx_link_ctrl dut (
    .clk_f(clk_f), .reset_L(reset_L), .enable(enable),
    .byte_vld_0(byte_vld_0), .byte_vld_1(byte_vld_1),
    .byte_0(byte_0), .byte_1(byte_1),
    .code_err_0(code_err_0), .code_err_1(code_err_1),
    .realign_0(realign_0), .realign_1(realign_1),
    .lane_active_0(lane_active_0), .lane_active_1(lane_active_1),
    .link_up(link_up),
    .data_out_0(data_out_0), .data_out_1(data_out_1),
    .valid_out_0(valid_out_0), .valid_out_1(valid_out_1),
    .err_cnt(err_cnt)
  );

  always #5 clk_f = ~clk_f;

  task automatic chk(input string tag, input logic [8:0] obs,
                     input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("lane_active_0", 9'(lane_active_0), 9'(m_act[0]));
    chk("lane_active_1", 9'(lane_active_1), 9'(m_act[1]));
    chk("valid_out_0", 9'(valid_out_0), 9'(m_valid[0]));
    chk("valid_out_1", 9'(valid_out_1), 9'(m_valid[1]));
    chk("data_out_0", 9'(data_out_0), 9'(m_data[0]));
    chk("data_out_1", 9'(data_out_1), 9'(m_data[1]));
    chk("realign_0", 9'(realign_0), 9'(m_realign[0]));
    chk("realign_1", 9'(realign_1), 9'(m_realign[1]));
    chk("link_up", 9'(link_up), 9'(m_link));
    chk("err_cnt", 9'(err_cnt), 9'(m_err));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_bc[i] = 0; m_to[i] = 0; m_run[i] = 0;
      m_valid[i] = 0; m_realign[i] = 0; m_data[i] = 0;
    end
    m_link = 0;
    m_err = 0;
  endtask

  // one byte-clock of the lane rules, applied to the driven inputs
  task automatic model_lane(input int i, input bit v, input int b,
                            input bit e);
    m_valid[i] = 0;
    m_realign[i] = 0;
    if (!enable) begin
      m_act[i] = 0; m_bc[i] = 0; m_to[i] = 0; m_run[i] = 0;
    end else if (v && !m_act[i]) begin
      m_bc[i] = (b == BC && !e) ? m_bc[i] + 1 : 0;
      m_to[i] = m_to[i] + 1;
      if (m_bc[i] == 4) begin
        m_act[i] = 1; m_bc[i] = 0; m_to[i] = 0;
      end else if (m_to[i] == 64) begin
        m_realign[i] = 1; m_bc[i] = 0; m_to[i] = 0;
      end
    end else if (v) begin
      if (e) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == 4) begin
          m_act[i] = 0; m_realign[i] = 1;
          m_run[i] = 0; m_bc[i] = 0; m_to[i] = 0;
        end
      end else begin
        m_run[i] = 0;
        if (b != BC) begin
          m_data[i] = b;
          m_valid[i] = 1;
        end
      end
    end
  endtask

  task automatic model_clk();
    m_link = (enable && m_act[0] == 1 && m_act[1] == 1) ? 1 : 0;
`ifdef PHY_RX_ERR_CNT_EN
    if (enable) begin
      m_err = m_err + int'(byte_vld_0 & code_err_0)
                    + int'(byte_vld_1 & code_err_1);
      if (m_err > 255) m_err = 255;
    end
`endif
    model_lane(0, byte_vld_0, byte_0, code_err_0);
    model_lane(1, byte_vld_1, byte_1, code_err_1);
  endtask

  task automatic step(input bit v0, input logic [7:0] b0, input bit e0,
                      input bit v1, input logic [7:0] b1, input bit e1);
    byte_vld_0 = v0; byte_0 = b0; code_err_0 = e0;
    byte_vld_1 = v1; byte_1 = b1; code_err_1 = e1;
    @(posedge clk_f);
    #1;
    model_clk();
    check_all();
  endtask

  task automatic do_reset();
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk_f);
    #1;
    check_all();
    reset_L = 1'b1;
  endtask

  function automatic logic [7:0] rnd_non_bc();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'hBC) b = 8'h5A;
    return b;
  endfunction

  initial begin
    model_reset();
    @(posedge clk_f);
    #1;
    check_all();
    reset_L = 1'b1;
    enable = 1'b1;

    repeat (4) step(1, 8'hBC, 0, 1, 8'hBC, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0);
    step(1, 8'hFF, 0, 1, 8'h11, 0);
    step(1, 8'hEE, 0, 1, 8'h22, 0);
    step(1, 8'hBC, 0, 1, 8'hBC, 0);
    step(1, 8'hDD, 0, 1, 8'h33, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0);

    do_reset();
    repeat (3) step(1, 8'hBC, 0, 0, 8'h00, 0);
    step(1, 8'hAA, 0, 0, 8'h00, 0);
    repeat (64) step(1, rnd_non_bc(), 0, 0, 8'h00, 0);

    do_reset();
    repeat (4) step(1, 8'hBC, 0, 1, 8'hBC, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0);
    repeat (4) step(1, 8'h42, 1, 1, rnd_non_bc(), 0);
    repeat (2) step(0, 8'h00, 0, 0, 8'h00, 0);

    repeat (4) step(1, 8'hBC, 0, 0, 8'h00, 0);
    repeat (3) step(1, 8'hBC, 1, 1, 8'h77, 0);
    step(1, 8'h66, 0, 0, 8'h00, 0);
    repeat (3) step(1, 8'h99, 1, 0, 8'h00, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0);

    enable = 1'b0;
    repeat (4) step(1, 8'hBC, 0, 1, 8'hBC, 0);
    enable = 1'b1;
    repeat (3) step(1, 8'hBC, 0, 1, 8'hBC, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0);
    step(1, 8'hBC, 0, 1, 8'hBC, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0);

    step(1, 8'h12, 0, 1, 8'h34, 0);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      enable = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 9) < 6) ? 8'hBC : rnd_non_bc(),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0,
           ($urandom_range(0, 9) < 6) ? 8'hBC : rnd_non_bc(),
           $urandom_range(0, 19) == 0);
    end

    enable = 1'b1;
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1),
           $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
